// File: rtl/soc_io_seg7_bin2bcd.sv
// -----------------------------------------------------------------------------
// soc_io_seg7_bin2bcd
//
// Sequential binary-to-BCD converter feeding the per-digit 7-segment decoders.
// Uses shift-and-add-3 (double dabble), one input bit per clock. It also
// produces a leading-zero blank mask and a saturating overflow flag.
//
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous reset, active-high
//   s_valid  in   input value valid
//   s_ready  out  block can accept a value (high only while idle)
//   s_data   in   [IN_W-1:0] unsigned binary value, sampled on the accept edge
//   m_valid  out  BCD result valid
//   m_ready  in   downstream accepts result
//   m_bcd    out  [4*DIGITS-1:0] packed BCD, nibble k = decimal digit k
//   m_blank  out  [DIGITS-1:0] 1 = digit k is a leading zero (bit 0 always 0)
//   m_ovf    out  input exceeded 10^DIGITS-1; m_bcd saturated to all nines
//
// Timing: the accepting edge is followed by IN_W shift edges. The last shift
// edge also loads the result registers and enters DONE, so m_valid is high
// after the 28th edge (default parameters), counting the accepting edge.
// -----------------------------------------------------------------------------
module soc_io_seg7_bin2bcd #(
  parameter int IN_W   = 27,
  parameter int DIGITS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [IN_W-1:0]       s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [4*DIGITS-1:0]   m_bcd,
  output logic [DIGITS-1:0]     m_blank,
  output logic                  m_ovf
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(IN_W + 1);

  // Elaboration-time 10^n; 64 bits covers any IN_W up to 63.
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  localparam logic [63:0] DEC_MAX = pow10(DIGITS) - 64'd1;

  // Per-nibble correction ahead of each shift. Nibbles never exceed 9 here,
  // so the 4-bit add cannot carry into the next nibble.
  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int k = 0; k < DIGITS; k++) begin
      if (b[4*k +: 4] >= 4'd5) r[4*k +: 4] = b[4*k +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Saturate to all nines when the input is out of decimal range.
  function automatic logic [BCD_W-1:0] sat_bcd(input logic [BCD_W-1:0] b,
                                               input logic ovf);
    return ovf ? {DIGITS{4'h9}} : b;
  endfunction

  // Digit k (k>0) is blank when it and every more significant digit is zero.
  function automatic logic [DIGITS-1:0] blank_mask(input logic [BCD_W-1:0] b);
    logic [DIGITS-1:0] m;
    logic              z;
    m = '0;
    z = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      z    = z & (b[4*k +: 4] == 4'd0);
      m[k] = z;
    end
    return m;
  endfunction

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t              state_q, state_d;
  logic [IN_W-1:0]     bin_q, bin_d;
  logic [BCD_W-1:0]    bcd_q, bcd_d;
  logic [CNT_W-1:0]    cnt_q;
  logic                ovf_q;
  logic [BCD_W-1:0]    m_bcd_q;
  logic [DIGITS-1:0]   m_blank_q;
  logic                m_ovf_q;
  logic [BCD_W+IN_W-1:0] sh_d;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (s_valid)        state_d = SHIFT;
      SHIFT:   if (cnt_q == '0)    state_d = DONE;
      DONE:    if (m_ready)        state_d = IDLE;
      default:                     state_d = IDLE;
    endcase
  end

  // Outputs are pure decodes of the state register, so no input reaches an
  // output combinationally.
  always_comb begin
    s_ready = (state_q == IDLE);
    m_valid = (state_q == DONE);
  end

  // One double-dabble step: correct nibbles, then shift {bcd, bin} left.
  always_comb begin
    sh_d  = {add3(bcd_q), bin_q} << 1;
    bcd_d = sh_d[BCD_W+IN_W-1:IN_W];
    bin_d = sh_d[IN_W-1:0];
  end

  // Datapath and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q     <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      m_bcd_q   <= '0;
      m_blank_q <= '0;
      m_ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (s_valid) begin
            bin_q <= s_data;
            bcd_q <= '0;
            ovf_q <= ({{(64-IN_W){1'b0}}, s_data} > DEC_MAX);
            cnt_q <= CNT_W'(IN_W - 1);
          end
        end
        SHIFT: begin
          bin_q <= bin_d;
          bcd_q <= bcd_d;
          if (cnt_q == '0) begin
            // Final shift: publish the finished, fixed-up result.
            m_bcd_q   <= sat_bcd(bcd_d, ovf_q);
            m_blank_q <= ovf_q ? '0 : blank_mask(bcd_d);
            m_ovf_q   <= ovf_q;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign m_bcd   = m_bcd_q;
  assign m_blank = m_blank_q;
  assign m_ovf   = m_ovf_q;

endmodule

// File: tb/tb_soc_io_seg7_bin2bcd.sv
// -----------------------------------------------------------------------------
// tb_soc_io_seg7_bin2bcd
//
// Self-checking bench for soc_io_seg7_bin2bcd with default parameters. Expected
// BCD digits, blank mask and overflow come from a decimal arithmetic model.
// -----------------------------------------------------------------------------
module tb_soc_io_seg7_bin2bcd;

  localparam int IN_W   = 27;
  localparam int DIGITS = 8;
  localparam int LAT    = IN_W;      // edges after the accepting edge
  localparam int PERIOD = IN_W + 2;  // back-to-back result spacing

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [26:0] s_data = '0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [31:0] m_bcd;
  logic [7:0]  m_blank;
  logic        m_ovf;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  soc_io_seg7_bin2bcd #(.IN_W(IN_W), .DIGITS(DIGITS)) dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_bcd   (m_bcd),
    .m_blank (m_blank),
    .m_ovf   (m_ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model (plain decimal arithmetic) --------------
  function automatic logic model_ovf(input int unsigned v);
    return v > 32'd99999999;
  endfunction

  function automatic logic [31:0] model_bcd(input int unsigned v);
    logic [31:0] r;
    int unsigned p;
    if (model_ovf(v)) return 32'h9999_9999;
    r = '0;
    p = 1;
    for (int k = 0; k < 8; k++) begin
      r[4*k +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [7:0] model_blank(input int unsigned v);
    logic [7:0] r;
    int unsigned p;
    r = '0;
    if (model_ovf(v)) return r;
    p = 10;
    for (int k = 1; k < 8; k++) begin
      r[k] = (v < p);
      p = p * 10;
    end
    return r;
  endfunction

  // ---------------- stimulus helpers (no checking inside) -------------------
  // Present v while idle, let it be accepted, scramble s_data, then wait for
  // m_valid. lat = edges after the accepting edge, or -1 on timeout.
  task automatic run_conv(input int unsigned v, output int lat);
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = 27'(v);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_data  = 27'($urandom);
    lat = 0;
    while (m_valid !== 1'b1 && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 10) s_data = 27'($urandom);
    end
    if (m_valid !== 1'b1) lat = -1;
  endtask

  task automatic drain();
    @(negedge clk);
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    m_ready = 1'b0;
  endtask

  // ---------------- tests --------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    #22;
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL rst_s_ready got=%b want=1", s_ready); end
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL rst_m_valid got=%b want=0", m_valid); end
    total++; if (m_bcd !== 32'h0) begin bad++; $display("FAIL rst_m_bcd got=%h want=0", m_bcd); end
    total++; if (m_blank !== 8'h0) begin bad++; $display("FAIL rst_m_blank got=%h want=0", m_blank); end
    total++; if (m_ovf !== 1'b0) begin bad++; $display("FAIL rst_m_ovf got=%b want=0", m_ovf); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_patterns();
    int unsigned vals[12];
    int lat;
    logic [31:0] held;
    vals[0] = 0;         vals[1] = 12345678;  vals[2] = 405;
    vals[3] = 99999999;  vals[4] = 100000000; vals[5] = 134217727;
    vals[6] = 9;         vals[7] = 10;
    for (int i = 8; i < 12; i++)
      vals[i] = (i % 2 == 0) ? ($urandom % 100000000) : $urandom_range(0, 134217727);
    foreach (vals[i]) begin
      run_conv(vals[i], lat);
      total++; if (lat != LAT) begin bad++; $display("FAIL latency[%0d] got=%0d want=%0d", vals[i], lat, LAT); end
      total++; if (m_bcd !== model_bcd(vals[i])) begin bad++; $display("FAIL bcd[%0d] got=%h want=%h", vals[i], m_bcd, model_bcd(vals[i])); end
      total++; if (m_blank !== model_blank(vals[i])) begin bad++; $display("FAIL blank[%0d] got=%h want=%h", vals[i], m_blank, model_blank(vals[i])); end
      total++; if (m_ovf !== model_ovf(vals[i])) begin bad++; $display("FAIL ovf[%0d] got=%b want=%b", vals[i], m_ovf, model_ovf(vals[i])); end
      held = m_bcd;
      drain();
      total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL post_xfer_valid[%0d] got=%b want=0", vals[i], m_valid); end
      total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL post_xfer_ready[%0d] got=%b want=1", vals[i], s_ready); end
      total++; if (m_bcd !== held) begin bad++; $display("FAIL post_xfer_hold[%0d] got=%h want=%h", vals[i], m_bcd, held); end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    run_conv(4321, lat);
    total++; if (lat != LAT) begin bad++; $display("FAIL bp_latency got=%0d want=%0d", lat, LAT); end
    s_valid = 1'b1;
    s_data  = 27'd777;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      total++;
      if (m_valid !== 1'b1 || s_ready !== 1'b0 || m_bcd !== 32'h0000_4321 ||
          m_blank !== 8'hF0 || m_ovf !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold[%0d] got v=%b r=%b bcd=%h blank=%h ovf=%b want v=1 r=0 bcd=00004321 blank=f0 ovf=0",
                 c, m_valid, s_ready, m_bcd, m_blank, m_ovf);
      end
    end
    @(negedge clk);
    s_valid = 1'b0;
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL bp_release_valid got=%b want=0", m_valid); end
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b want=1", s_ready); end
    total++; if (m_bcd !== 32'h0000_4321) begin bad++; $display("FAIL bp_release_hold got=%h want=00004321", m_bcd); end
  endtask

  task automatic test_back_to_back();
    int t1, t2, n;
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = 27'd7;
    m_ready = 1'b1;
    @(posedge clk);        // accepts 7
    #1;
    s_data = 27'd59;       // changes mid-conversion; must not disturb 7
    n = 0;
    while (m_valid !== 1'b1 && n < 60) begin @(posedge clk); #1; n++; end
    t1 = cyc;
    total++; if (m_valid !== 1'b1 || m_bcd !== 32'h0000_0007) begin bad++; $display("FAIL b2b_first got v=%b bcd=%h want v=1 bcd=00000007", m_valid, m_bcd); end
    @(posedge clk);        // transfer
    @(posedge clk);        // accepts 59
    #1;
    s_data = 27'($urandom);
    n = 0;
    while (m_valid !== 1'b1 && n < 60) begin @(posedge clk); #1; n++; end
    t2 = cyc;
    s_valid = 1'b0;
    total++; if (m_valid !== 1'b1 || m_bcd !== 32'h0000_0059) begin bad++; $display("FAIL b2b_second got v=%b bcd=%h want v=1 bcd=00000059", m_valid, m_bcd); end
    total++; if (t2 - t1 != PERIOD) begin bad++; $display("FAIL b2b_spacing got=%0d want=%0d", t2 - t1, PERIOD); end
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    total++; if (s_ready !== 1'b1 || m_valid !== 1'b0) begin bad++; $display("FAIL b2b_end got r=%b v=%b want r=1 v=0", s_ready, m_valid); end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic seen;
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = 27'd12345;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL rstmid_async_ready got=%b want=1", s_ready); end
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL rstmid_async_valid got=%b want=0", m_valid); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (m_valid === 1'b1) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL rstmid_no_valid got=%b want=0", seen); end
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready got=%b want=1", s_ready); end
    run_conv(31, lat);
    total++; if (lat != LAT) begin bad++; $display("FAIL rstmid_latency got=%0d want=%0d", lat, LAT); end
    total++; if (m_bcd !== 32'h0000_0031) begin bad++; $display("FAIL rstmid_bcd got=%h want=00000031", m_bcd); end
    total++; if (m_blank !== 8'hFC) begin bad++; $display("FAIL rstmid_blank got=%h want=fc", m_blank); end
    drain();
  endtask

  initial begin
    test_reset();
    test_patterns();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
